// File: rtl/hart_pkg.sv
// hart_pkg: shared definitions for the RV32I hart pipeline.
//
// Holds the width and bit layout of the packed control bundle that travels
// from ID into EX, plus the all-zero bubble encoding. A bubble has every
// side-effecting bit clear (reg_write, mem_read, mem_write, jal, jalr, branch),
// so an instruction slot holding it can never write state or redirect the PC.
//
// Control bundle layout (LSB first):
//   [2:0]   ALUOp
//   [6:3]   func
//   [9:7]   func3
//   [10]    jal
//   [11]    jalr
//   [12]    branch
//   [13]    op1_pc     (ALU operand 1 = PC instead of rs1)
//   [14]    op2_imm    (ALU operand 2 = immediate instead of rs2)
//   [15]    mem_read
//   [16]    mem_write
//   [17]    reg_write
//   [19:18] wb_sel
package hart_pkg;

    localparam int CTRL_W = 20;

    localparam int CTRL_ALUOP_LSB  = 0;
    localparam int CTRL_ALUOP_W    = 3;
    localparam int CTRL_FUNC_LSB   = 3;
    localparam int CTRL_FUNC_W     = 4;
    localparam int CTRL_FUNC3_LSB  = 7;
    localparam int CTRL_FUNC3_W    = 3;
    localparam int CTRL_JAL        = 10;
    localparam int CTRL_JALR       = 11;
    localparam int CTRL_BRANCH     = 12;
    localparam int CTRL_OP1_PC     = 13;
    localparam int CTRL_OP2_IMM    = 14;
    localparam int CTRL_MEM_READ   = 15;
    localparam int CTRL_MEM_WRITE  = 16;
    localparam int CTRL_REG_WRITE  = 17;
    localparam int CTRL_WB_SEL_LSB = 18;
    localparam int CTRL_WB_SEL_W   = 2;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: combinational forwarding mux for one EX source operand.
//
// Picks the newest in-flight value for source register i_rs:
//   EX/MEM result if that producer writes i_rs, else MEM/WB value if that
//   producer writes i_rs, else the value read from the register file at ID.
// x0 is never forwarded, so a producer with rd=0 cannot override the
// hard-wired zero.
//
// Ports:
//   i_rs, i_rs_data                       source address and regfile data
//   i_exm_valid/regwrite/rd/value         EX/MEM producer
//   i_mwb_valid/regwrite/rd/value         MEM/WB producer
//   o_data                                forwarded operand
module fwd_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic [XLEN-1:0] i_rs_data,
    input  logic            i_exm_valid,
    input  logic            i_exm_regwrite,
    input  logic [RA_W-1:0] i_exm_rd,
    input  logic [XLEN-1:0] i_exm_value,
    input  logic            i_mwb_valid,
    input  logic            i_mwb_regwrite,
    input  logic [RA_W-1:0] i_mwb_rd,
    input  logic [XLEN-1:0] i_mwb_value,
    output logic [XLEN-1:0] o_data
);

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = i_exm_valid && i_exm_regwrite && (i_exm_rd != '0) && (i_exm_rd == i_rs);
    assign mwb_hit = i_mwb_valid && i_mwb_regwrite && (i_mwb_rd != '0) && (i_mwb_rd == i_rs);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        o_data = i_rs_data;
        if (exm_hit) begin
            o_data = i_exm_value;
        end else if (mwb_hit) begin
            o_data = i_mwb_value;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV32I hart.
//
// Captures the decoded instruction from ID, resolves operand forwarding from
// EX/MEM and MEM/WB against the registered source addresses, detects load-use
// hazards (stalling IF/ID for one cycle) and inserts a bubble on an EX redirect.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_id_*                       decoded instruction from ID
//   i_flush                      EX redirect: squash the instruction in ID
//   i_exm_*, i_mwb_*             downstream producers for forwarding
//   o_stall                      hold PC and IF/ID this cycle
//   o_valid, o_pc, o_imm, o_rd   registered instruction state for EX
//   o_op1, o_op2                 forwarded, selected ALU operands
//   o_store_data                 forwarded rs2 for stores
//   o_ctrl                       registered control bundle
module id_ex_stage
    import hart_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = hart_pkg::CTRL_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [RA_W-1:0]   i_id_rs1,
    input  logic [RA_W-1:0]   i_id_rs2,
    input  logic [RA_W-1:0]   i_id_rd,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic              i_flush,
    input  logic              i_exm_valid,
    input  logic              i_exm_regwrite,
    input  logic [RA_W-1:0]   i_exm_rd,
    input  logic [XLEN-1:0]   i_exm_value,
    input  logic              i_mwb_valid,
    input  logic              i_mwb_regwrite,
    input  logic [RA_W-1:0]   i_mwb_rd,
    input  logic [XLEN-1:0]   i_mwb_value,
    output logic              o_stall,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_imm,
    output logic [XLEN-1:0]   o_op1,
    output logic [XLEN-1:0]   o_op2,
    output logic [XLEN-1:0]   o_store_data,
    output logic [RA_W-1:0]   o_rd,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              vld_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [RA_W-1:0]   rd_p1;
    logic [RA_W-1:0]   rs1_p1;
    logic [RA_W-1:0]   rs2_p1;
    logic [XLEN-1:0]   rs1_data_p1;
    logic [XLEN-1:0]   rs2_data_p1;
    logic [CTRL_W-1:0] ctrl_p1;

    logic              load_use;
    logic              bubble;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    // Both source fields are compared whatever the instruction format; a
    // spurious stall on an unused rs2 field only costs a cycle.
    assign load_use = vld_p1 && ctrl_p1[CTRL_MEM_READ] && (rd_p1 != '0) && i_id_valid &&
                      ((i_id_rs1 == rd_p1) || (i_id_rs2 == rd_p1));

    // A flush makes the ID instruction wrong-path, so it must not be held.
    assign o_stall = load_use && !i_flush;
    assign bubble  = i_flush || load_use;

    // ---- ID -> EX boundary ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= CTRL_BUBBLE;
            pc_p1       <= '0;
            imm_p1      <= '0;
            rd_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
        end else if (bubble) begin
            // Only valid/ctrl need clearing; datapath fields keep their value.
            vld_p1      <= 1'b0;
            ctrl_p1     <= CTRL_BUBBLE;
        end else begin
            vld_p1      <= i_id_valid;
            ctrl_p1     <= i_id_ctrl;
            pc_p1       <= i_id_pc;
            imm_p1      <= i_id_imm;
            rd_p1       <= i_id_rd;
            rs1_p1      <= i_id_rs1;
            rs2_p1      <= i_id_rs2;
            rs1_data_p1 <= i_id_rs1_data;
            rs2_data_p1 <= i_id_rs2_data;
        end
    end

    // ---- EX operand resolution ----
    fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .i_rs           (rs1_p1),
        .i_rs_data      (rs1_data_p1),
        .i_exm_valid    (i_exm_valid),
        .i_exm_regwrite (i_exm_regwrite),
        .i_exm_rd       (i_exm_rd),
        .i_exm_value    (i_exm_value),
        .i_mwb_valid    (i_mwb_valid),
        .i_mwb_regwrite (i_mwb_regwrite),
        .i_mwb_rd       (i_mwb_rd),
        .i_mwb_value    (i_mwb_value),
        .o_data         (fwd_rs1)
    );

    fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .i_rs           (rs2_p1),
        .i_rs_data      (rs2_data_p1),
        .i_exm_valid    (i_exm_valid),
        .i_exm_regwrite (i_exm_regwrite),
        .i_exm_rd       (i_exm_rd),
        .i_exm_value    (i_exm_value),
        .i_mwb_valid    (i_mwb_valid),
        .i_mwb_regwrite (i_mwb_regwrite),
        .i_mwb_rd       (i_mwb_rd),
        .i_mwb_value    (i_mwb_value),
        .o_data         (fwd_rs2)
    );

    assign o_valid      = vld_p1;
    assign o_pc         = pc_p1;
    assign o_imm        = imm_p1;
    assign o_rd         = rd_p1;
    assign o_ctrl       = ctrl_p1;
    assign o_op1        = ctrl_p1[CTRL_OP1_PC]  ? pc_p1  : fwd_rs1;
    assign o_op2        = ctrl_p1[CTRL_OP2_IMM] ? imm_p1 : fwd_rs2;
    assign o_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage.
module tb_id_ex_stage;
    import hart_pkg::*;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_id_valid;
    logic [XLEN-1:0]   i_id_pc;
    logic [RA_W-1:0]   i_id_rs1, i_id_rs2, i_id_rd;
    logic [XLEN-1:0]   i_id_rs1_data, i_id_rs2_data, i_id_imm;
    logic [CTRL_W-1:0] i_id_ctrl;
    logic              i_flush;
    logic              i_exm_valid, i_exm_regwrite;
    logic [RA_W-1:0]   i_exm_rd;
    logic [XLEN-1:0]   i_exm_value;
    logic              i_mwb_valid, i_mwb_regwrite;
    logic [RA_W-1:0]   i_mwb_rd;
    logic [XLEN-1:0]   i_mwb_value;
    logic              o_stall, o_valid;
    logic [XLEN-1:0]   o_pc, o_imm, o_op1, o_op2, o_store_data;
    logic [RA_W-1:0]   o_rd;
    logic [CTRL_W-1:0] o_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
        .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
        .i_id_imm(i_id_imm), .i_id_ctrl(i_id_ctrl), .i_flush(i_flush),
        .i_exm_valid(i_exm_valid), .i_exm_regwrite(i_exm_regwrite),
        .i_exm_rd(i_exm_rd), .i_exm_value(i_exm_value),
        .i_mwb_valid(i_mwb_valid), .i_mwb_regwrite(i_mwb_regwrite),
        .i_mwb_rd(i_mwb_rd), .i_mwb_value(i_mwb_value),
        .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc), .o_imm(o_imm),
        .o_op1(o_op1), .o_op2(o_op2), .o_store_data(o_store_data),
        .o_rd(o_rd), .o_ctrl(o_ctrl)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_id_valid = 1'b0; i_id_pc = '0; i_id_rs1 = '0; i_id_rs2 = '0; i_id_rd = '0;
        i_id_rs1_data = '0; i_id_rs2_data = '0; i_id_imm = '0; i_id_ctrl = '0;
        i_flush = 1'b0;
        i_exm_valid = 1'b0; i_exm_regwrite = 1'b0; i_exm_rd = '0; i_exm_value = '0;
        i_mwb_valid = 1'b0; i_mwb_regwrite = 1'b0; i_mwb_rd = '0; i_mwb_value = '0;
    endtask

    task automatic drive_id(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1,
                            input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd,
                            input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                            input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
        i_id_valid = 1'b1; i_id_pc = pc; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd;
        i_id_rs1_data = d1; i_id_rs2_data = d2; i_id_imm = imm; i_id_ctrl = ctrl;
    endtask

    // Captures `lw x8, 0(x2)` at pc 0x40 into EX.
    task automatic load_lw_x8();
        logic [CTRL_W-1:0] c;
        c = '0; c[CTRL_MEM_READ] = 1'b1; c[CTRL_REG_WRITE] = 1'b1; c[CTRL_OP2_IMM] = 1'b1;
        drive_id(32'h40, 5'd2, 5'd0, 5'd8, 32'h1000, 32'h0, 32'h0, c);
        tick();
    endtask

    task automatic test_reset();
        logic [CTRL_W-1:0] c;
        c = '0; c[CTRL_REG_WRITE] = 1'b1; c[CTRL_JAL] = 1'b1;
        idle_inputs();
        i_rst = 1'b1;
        drive_id(32'h200, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, c);
        tick(); tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", o_ctrl); end
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_pc); end
        i_rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_exm_forward();
        logic [CTRL_W-1:0] c;
        c = '0; c[CTRL_REG_WRITE] = 1'b1; c[CTRL_ALUOP_LSB] = 1'b1;
        // sub x6, x5, x7 with stale x5 regfile data and x7 = 3
        drive_id(32'h104, 5'd5, 5'd7, 5'd6, 32'hDEAD, 32'd3, 32'h0, c);
        tick();
        idle_inputs();
        i_exm_valid = 1'b1; i_exm_regwrite = 1'b1; i_exm_rd = 5'd5; i_exm_value = 32'h1234;
        #1;
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL exm_valid: got %b want 1", o_valid); end
        n_checks++; if (o_op1 !== 32'h1234) begin n_fail++; $display("FAIL exm_op1: got %h want 00001234", o_op1); end
        n_checks++; if (o_op2 !== 32'd3) begin n_fail++; $display("FAIL exm_op2: got %h want 00000003", o_op2); end
        n_checks++; if (o_rd !== 5'd6) begin n_fail++; $display("FAIL exm_rd: got %0d want 6", o_rd); end
        n_checks++; if (o_store_data !== 32'd3) begin n_fail++; $display("FAIL exm_store: got %h want 00000003", o_store_data); end
        idle_inputs();
    endtask

    task automatic test_fwd_priority();
        logic [CTRL_W-1:0] c;
        c = '0; c[CTRL_REG_WRITE] = 1'b1;
        drive_id(32'h108, 5'd5, 5'd0, 5'd9, 32'h55, 32'h66, 32'h0, c);
        tick();
        idle_inputs();
        i_exm_valid = 1'b1; i_exm_regwrite = 1'b1; i_exm_rd = 5'd5; i_exm_value = 32'hA;
        i_mwb_valid = 1'b1; i_mwb_regwrite = 1'b1; i_mwb_rd = 5'd5; i_mwb_value = 32'hB;
        #1;
        n_checks++; if (o_op1 !== 32'hA) begin n_fail++; $display("FAIL prio_exm: got %h want 0000000a", o_op1); end
        i_exm_regwrite = 1'b0;
        #1;
        n_checks++; if (o_op1 !== 32'hB) begin n_fail++; $display("FAIL prio_mwb: got %h want 0000000b", o_op1); end
        i_exm_regwrite = 1'b1; i_exm_valid = 1'b0;
        #1;
        n_checks++; if (o_op1 !== 32'hB) begin n_fail++; $display("FAIL prio_exm_invalid: got %h want 0000000b", o_op1); end
        i_exm_valid = 1'b1; i_exm_rd = 5'd0; i_mwb_rd = 5'd0;
        #1;
        n_checks++; if (o_op1 !== 32'h55) begin n_fail++; $display("FAIL prio_x0_op1: got %h want 00000055", o_op1); end
        n_checks++; if (o_op2 !== 32'h66) begin n_fail++; $display("FAIL prio_x0_op2: got %h want 00000066", o_op2); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        logic [CTRL_W-1:0] c;
        load_lw_x8();
        // addi x9, x8, 1
        c = '0; c[CTRL_REG_WRITE] = 1'b1; c[CTRL_OP2_IMM] = 1'b1;
        drive_id(32'h44, 5'd8, 5'd1, 5'd9, 32'h0, 32'h0, 32'd1, c);
        #1;
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", o_stall); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %b want 0", o_valid); end
        n_checks++; if (o_ctrl !== '0) begin n_fail++; $display("FAIL lu_bubble_ctrl: got %h want 0", o_ctrl); end
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b want 0", o_stall); end
        // lw now in EX/MEM; ID still holds addi
        i_exm_valid = 1'b1; i_exm_regwrite = 1'b1; i_exm_rd = 5'd8; i_exm_value = 32'h1000;
        tick();
        // lw now in MEM/WB with loaded data, bubble in EX/MEM
        idle_inputs();
        i_mwb_valid = 1'b1; i_mwb_regwrite = 1'b1; i_mwb_rd = 5'd8; i_mwb_value = 32'h77;
        #1;
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lu_addi_valid: got %b want 1", o_valid); end
        n_checks++; if (o_rd !== 5'd9) begin n_fail++; $display("FAIL lu_addi_rd: got %0d want 9", o_rd); end
        n_checks++; if (o_op1 !== 32'h77) begin n_fail++; $display("FAIL lu_addi_op1: got %h want 00000077", o_op1); end
        n_checks++; if (o_op2 !== 32'd1) begin n_fail++; $display("FAIL lu_addi_op2: got %h want 00000001", o_op2); end
        idle_inputs();
        tick();
    endtask

    task automatic test_no_hazard();
        logic [CTRL_W-1:0] c;
        load_lw_x8();
        c = '0; c[CTRL_REG_WRITE] = 1'b1;
        // rs2 match alone must stall
        drive_id(32'h44, 5'd3, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0, c);
        #1;
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL nh_rs2_stall: got %b want 1", o_stall); end
        // unrelated sources
        i_id_rs2 = 5'd4;
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL nh_unrelated: got %b want 0", o_stall); end
        // invalid ID slot
        i_id_rs1 = 5'd8; i_id_valid = 1'b0;
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL nh_id_invalid: got %b want 0", o_stall); end
        idle_inputs();
        tick();
        // load to x0 never stalls
        c = '0; c[CTRL_MEM_READ] = 1'b1; c[CTRL_REG_WRITE] = 1'b1;
        drive_id(32'h48, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, c);
        tick();
        c = '0; c[CTRL_REG_WRITE] = 1'b1;
        drive_id(32'h4C, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, c);
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL nh_x0_load: got %b want 0", o_stall); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_over_stall();
        logic [CTRL_W-1:0] c;
        load_lw_x8();
        c = '0; c[CTRL_REG_WRITE] = 1'b1;
        drive_id(32'h44, 5'd8, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, c);
        i_flush = 1'b1;
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %b want 0", o_stall); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", o_valid); end
        n_checks++; if (o_ctrl !== '0) begin n_fail++; $display("FAIL fl_ctrl: got %h want 0", o_ctrl); end
        n_checks++; if (o_pc !== 32'h40) begin n_fail++; $display("FAIL fl_pc_hold: got %h want 00000040", o_pc); end
        idle_inputs();
        // flush alone on a normal instruction also bubbles
        drive_id(32'h80, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, c);
        i_flush = 1'b1;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL fl_plain_valid: got %b want 0", o_valid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_op_select();
        logic [CTRL_W-1:0] c;
        c = '0; c[CTRL_JAL] = 1'b1; c[CTRL_OP1_PC] = 1'b1; c[CTRL_OP2_IMM] = 1'b1;
        c[CTRL_REG_WRITE] = 1'b1;
        drive_id(32'h100, 5'd1, 5'd2, 5'd1, 32'h999, 32'h888, 32'h20, c);
        tick();
        idle_inputs();
        #1;
        n_checks++; if (o_op1 !== 32'h100) begin n_fail++; $display("FAIL sel_op1: got %h want 00000100", o_op1); end
        n_checks++; if (o_op2 !== 32'h20) begin n_fail++; $display("FAIL sel_op2: got %h want 00000020", o_op2); end
        n_checks++; if (o_ctrl[CTRL_JAL] !== 1'b1) begin n_fail++; $display("FAIL sel_jal: got %b want 1", o_ctrl[CTRL_JAL]); end
        n_checks++; if (o_store_data !== 32'h888) begin n_fail++; $display("FAIL sel_store: got %h want 00000888", o_store_data); end
        n_checks++; if (o_imm !== 32'h20) begin n_fail++; $display("FAIL sel_imm: got %h want 00000020", o_imm); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [CTRL_W-1:0] c;
        load_lw_x8();
        c = '0; c[CTRL_REG_WRITE] = 1'b1;
        drive_id(32'h44, 5'd8, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, c);
        #1;
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL rms_pre_stall: got %b want 1", o_stall); end
        i_rst = 1'b1;
        tick();
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall: got %b want 0", o_stall); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rms_valid: got %b want 0", o_valid); end
        i_rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_exm_forward();
        test_fwd_priority();
        test_load_use();
        test_no_hazard();
        test_flush_over_stall();
        test_op_select();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I hart, sitting directly upstream of the EX stage.
- Captures the decoded instruction from ID.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and stalls IF/ID.
- Inserts a bubble on a taken branch or jump redirect.
- Its outputs drive EX directly: operands, immediate, PC, ALU controls and branch controls.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- CTRL_W, 20, width of the packed control bundle (fields in package).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_pc  in  XLEN  PC of ID instruction
- i_id_rs1, i_id_rs2  in  RA_W  source register addresses
- i_id_rd  in  RA_W  destination address
- i_id_rs1_data, i_id_rs2_data  in  XLEN  register file read data (regfile is write-through, so WB same-cycle writes are already visible)
- i_id_imm  in  XLEN  decoded immediate
- i_id_ctrl  in  CTRL_W  packed control bundle
- i_flush  in  1  EX redirect (PC_Select != 0 for the instruction currently in EX)
- i_exm_valid, i_exm_regwrite  in  1  EX/MEM producer state
- i_exm_rd  in  RA_W  EX/MEM destination
- i_exm_value  in  XLEN  EX/MEM ALU result
- i_mwb_valid, i_mwb_regwrite  in  1  MEM/WB producer state
- i_mwb_rd  in  RA_W  MEM/WB destination
- i_mwb_value  in  XLEN  MEM/WB writeback value
- o_stall  out  1  hold PC and IF/ID this cycle
- o_valid  out  1  EX holds a real instruction
- o_pc  out  XLEN  registered PC
- o_imm  out  XLEN  registered immediate
- o_op1, o_op2  out  XLEN  forwarded and selected ALU operands
- o_store_data  out  XLEN  forwarded rs2 value
- o_rd  out  RA_W  registered destination
- o_ctrl  out  CTRL_W  registered control bundle; bits for ALUOp, func, func3, jal, jalr and branch feed EX

Behaviour:
- Register update, every rising i_clk, in priority order:
  1. i_rst → all state 0: o_valid=0, ctrl=0, pc/imm/rd/rs data=0.
  2. i_flush → load bubble: valid=0, ctrl=0; data fields don't-care, but hold their value.
  3. Load-use hazard → load bubble, same as flush.
  4. Otherwise capture all ID inputs; valid = i_id_valid.
- Bubble invariant: ctrl=0 means regwrite=0, mem_read=0, mem_write=0, jal=0, jalr=0, branch=0, so EX yields PC_Select=0.
- Load-use hazard (combinational), asserted when all hold:
  - o_valid & ctrl.mem_read & o_rd!=0 & i_id_valid;
  - and (i_id_rs1==o_rd, or i_id_rs2==o_rd).
  - Both source fields are compared regardless of format; conservative false stalls are accepted.
- Stall output: o_stall = hazard & ~i_flush. Flush overrides stall, because the ID instruction is wrong-path. A hazard costs exactly one bubble cycle.
- Forwarding (combinational, per source rsN in the registered state):
  - If i_exm_valid & i_exm_regwrite & i_exm_rd!=0 & i_exm_rd==rsN → i_exm_value.
  - Else if the same test passes on the mwb inputs → i_mwb_value.
  - Else the registered rsN data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
  - EX/MEM forwarding is never applied to a load in EX/MEM; the load-use stall guarantees this case does not arise.
- Operand select:
  - o_op1 = ctrl.op1_pc ? o_pc : fwd_rs1.
  - o_op2 = ctrl.op2_imm ? o_imm : fwd_rs2.
  - o_store_data = fwd_rs2 always.
- Registered rs1/rs2 addresses are held internally for forwarding; they are not ports.
- Latency: one cycle from ID inputs to registered outputs. Forwarding adds no cycles.
- Reset mid-stall: o_stall=0 on the cycle after reset, since o_valid=0.

Decomposition:
- Package hart_pkg:
  - CTRL_W and the field offsets of the ctrl bundle: ALUOp[2:0], func[3:0], func3[2:0], jal, jalr, branch, op1_pc, op2_imm, mem_read, mem_write, reg_write, wb_sel[1:0].
  - Localparam CTRL_BUBBLE = 0.
- One sub-module: fwd_unit.
  - Pure combinational two-source forwarding mux.
  - Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset: hold i_rst 2 cycles with i_id_valid=1 → o_valid=0, o_ctrl=0, o_stall=0.
- EX/MEM forwarding: `add x5` in EX/MEM (value 0x1234); ID `sub x6,x5,x7` captured with x7 data=3 → o_op1=0x1234, o_op2=3.
- Forwarding priority: EX/MEM rd=5 value=0xA, MEM/WB rd=5 value=0xB, registered rs1=5 → o_op1=0xA. With rd=0 on both producers → raw regfile data.
- Load-use: `lw x8` captured; ID `addi x9,x8,1`:
  - o_stall=1 for one cycle; next cycle o_valid=0;
  - the following cycle addi is captured and its op1 is forwarded from MEM/WB.
- Flush over stall: assert the hazard and i_flush together → o_stall=0; next cycle o_valid=0, ctrl=0.
- Operand select: `jal` with op1_pc=1, op2_imm=1, pc=0x100, imm=0x20 → o_op1=0x100, o_op2=0x20; o_ctrl.jal=1 passes to EX.
